// File: rtl/fifo_write_if.sv
// rtl/fifo_write_if.sv - write-side bus into the SDRAM write FIFO
// Purpose: groups the strobe/data pair written into the SDRAM write FIFO
//          together with that FIFO's fill level.
// Signals:
//   write_en    - one-cycle write strobe (master -> slave)
//   write_data  - byte written, valid while write_en=1 (master -> slave)
//   wr_fifo_num - current fill level of the write FIFO (slave -> master)
interface fifo_write_if;
  logic        write_en;
  logic [7:0]  write_data;
  logic [15:0] wr_fifo_num;

  modport master (output write_en, output write_data, input wr_fifo_num);
  modport slave  (input write_en, input write_data, output wr_fifo_num);
endinterface

// File: rtl/fifo_write.sv
// rtl/fifo_write.sv - 8N1 UART receiver buffering bytes and draining bursts into the SDRAM write FIFO
// Purpose: deserialises UART frames on rx into a circular byte buffer and,
//          once a full burst is buffered and the write FIFO has room, drains
//          it as a gap-free run of write strobes.
// Ports:
//   sys_clk   - system clock
//   sys_rst   - synchronous active-high reset
//   rx        - asynchronous UART line, idle high
//   burst_num - bytes per burst, 0 disables draining
//   buf_num   - bytes currently held in the buffer (0..512)
//   frame_err - one-cycle pulse on a stop bit sampled low
//   overflow  - one-cycle pulse when a good byte is dropped on a full buffer
//   wif       - write-FIFO bus (write_en, write_data, wr_fifo_num)
module fifo_write #(
  parameter logic [12:0] BAUD_CNT_END      = 13'd5207,
  parameter logic [12:0] BAUD_CNT_END_HALF = 13'd2603,
  parameter int          BUF_AW            = 9,
  parameter logic [15:0] WFIFO_DEPTH       = 16'd1024
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         rx,
  input  logic [8:0]   burst_num,
  output logic [9:0]   buf_num,
  output logic         frame_err,
  output logic         overflow,
  fifo_write_if.master wif
);
  localparam int         DEPTH = 1 << BUF_AW;
  localparam logic [9:0] FULL  = 10'(DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic {D_IDLE, D_BURST} dr_state_t;

  logic              rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  rx_state_t         rstate_q, rstate_d;
  logic [12:0]       baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic [BUF_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [9:0]        buf_num_q, buf_num_d;
  dr_state_t         dstate_q, dstate_d;
  logic [8:0]        pop_left_q, pop_left_d;
  logic              write_en_q, write_en_d;
  logic [7:0]        write_data_q, write_data_d;

  logic [7:0]        mem [DEPTH];

  logic              start_edge, sample, full, push, pop, start_ok;
  logic [16:0]       room_sum;

  // Receiver: synchroniser, bit timing and frame FSM
  always_comb begin
    rx_s1_d     = rx;
    rx_s2_d     = rx_s1_q;
    rstate_d    = rstate_q;
    baud_cnt_d  = 13'd0;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    // Falling edge on the synchronised line: older stage high, newer low.
    start_edge = rx_s2_q & ~rx_s1_q;
    sample     = (baud_cnt_q == BAUD_CNT_END_HALF);

    if (rstate_q != R_IDLE) begin
      baud_cnt_d = (baud_cnt_q == BAUD_CNT_END) ? 13'd0 : baud_cnt_q + 13'd1;
    end

    case (rstate_q)
      R_IDLE: begin
        if (start_edge) rstate_d = R_START;
      end
      R_START: begin
        if (sample) begin
          bit_cnt_d = 3'd0;
          rstate_d  = rx_s2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (sample) begin
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rstate_d = R_STOP;
        end
      end
      R_STOP: begin
        // Leave at mid stop bit so a following start edge is not missed.
        if (sample) begin
          rx_valid_d  = rx_s2_q;
          frame_err_d = ~rx_s2_q;
          rstate_d    = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Buffer bookkeeping and drain FSM
  always_comb begin
    full     = (buf_num_q == FULL);
    push     = rx_valid_q & ~full;
    overflow = rx_valid_q & full;
    pop      = (dstate_q == D_BURST);

    wptr_d = push ? wptr_q + BUF_AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + BUF_AW'(1) : rptr_q;

    buf_num_d = buf_num_q;
    if (push && !pop)      buf_num_d = buf_num_q + 10'd1;
    else if (!push && pop) buf_num_d = buf_num_q - 10'd1;

    room_sum = {1'b0, wif.wr_fifo_num} + {8'd0, burst_num};
    start_ok = (burst_num != 9'd0) && (buf_num_q >= {1'b0, burst_num}) &&
               (room_sum <= {1'b0, WFIFO_DEPTH});

    dstate_d   = dstate_q;
    pop_left_d = pop_left_q;
    if (dstate_q == D_IDLE) begin
      if (start_ok) begin
        dstate_d   = D_BURST;
        pop_left_d = burst_num;
      end
    end else begin
      pop_left_d = pop_left_q - 9'd1;
      if (pop_left_q == 9'd1) dstate_d = D_IDLE;
    end

    write_en_d   = pop;
    write_data_d = pop ? mem[rptr_q] : write_data_q;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst && push) mem[wptr_q] <= shift_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rstate_q     <= R_IDLE;
      baud_cnt_q   <= 13'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      buf_num_q    <= 10'd0;
      dstate_q     <= D_IDLE;
      pop_left_q   <= 9'd0;
      write_en_q   <= 1'b0;
      write_data_q <= 8'h00;
    end else begin
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rstate_q     <= rstate_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      buf_num_q    <= buf_num_d;
      dstate_q     <= dstate_d;
      pop_left_q   <= pop_left_d;
      write_en_q   <= write_en_d;
      write_data_q <= write_data_d;
    end
  end

  assign buf_num        = buf_num_q;
  assign frame_err      = frame_err_q;
  assign wif.write_en   = write_en_q;
  assign wif.write_data = write_data_q;
endmodule
